bpu_btb: RTL

Parametrised branch-target unit: the execute-stage target adder extended with a direct-mapped branch target buffer, 2-bit saturating direction counters, and misprediction detection. Fetch issues a lookup and gets a registered prediction one cycle later. Execute resolves a control instruction; the block computes its real target, flags a redirect if fetch guessed wrong, and trains the table on the same edge.

---
 rtl/bpu_btb.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bpu_btb.sv
// Branch-target unit: execute-stage target adder, direct-mapped BTB with 2-bit
// direction counters, misprediction detection and a one-cycle registered fetch lookup.
module bpu_btb #(
    parameter int XLEN    = 64,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            f_valid,
    input  logic [XLEN-1:0] f_pc,
    output logic            p_valid,
    output logic            p_hit,
    output logic            p_taken,
    output logic [XLEN-1:0] p_target,
    input  logic            r_valid,
    input  logic [XLEN-1:0] r_pc,
    input  logic            r_is_branch,
    input  logic            r_is_jump,
    input  logic            r_is_jalr,
    input  logic            r_taken,
    input  logic [XLEN-1:0] r_sextimm,
    input  logic [XLEN-1:0] r_jalr_src,
    input  logic            r_pred_taken,
    input  logic [XLEN-1:0] r_pred_target,
    output logic [XLEN-1:0] r_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);

    localparam int CNT_BITS = 2;
    localparam int IDX      = $clog2(ENTRIES);
    localparam int TAG_W    = XLEN - IDX - 2;

    function automatic logic [CNT_BITS-1:0] cnt_next(input logic [CNT_BITS-1:0] cnt,
                                                     input logic up);
        logic [CNT_BITS-1:0] res;
        res = cnt;
        if (up) begin
            if (cnt != 2'd3) res = cnt + 2'd1;
            else             res = cnt;
        end else begin
            if (cnt != 2'd0) res = cnt - 2'd1;
            else             res = cnt;
        end
        return res;
    endfunction

    logic                valid_r   [ENTRIES];
    logic [TAG_W-1:0]    tag_r     [ENTRIES];
    logic [XLEN-1:0]     target_r  [ENTRIES];
    logic                is_jump_r [ENTRIES];
    logic [CNT_BITS-1:0] cnt_r     [ENTRIES];

    logic [IDX-1:0]   f_idx_s;
    logic [TAG_W-1:0] f_tag_s;
    logic             f_hit_s;
    logic             f_taken_s;
    logic [XLEN-1:0]  f_target_s;

    logic [IDX-1:0]   r_idx_s;
    logic [TAG_W-1:0] r_tag_s;
    logic             r_hit_s;
    logic [XLEN-1:0]  r_pc4_s;
    logic             act_taken_s;
    logic [XLEN-1:0]  act_next_s;
    logic [XLEN-1:0]  pred_next_s;
    logic             train_s;

    // Fetch-side table read; uses pre-update contents, giving read-before-write.
    always_comb begin
        f_idx_s    = f_pc[IDX+1:2];
        f_tag_s    = f_pc[XLEN-1:IDX+2];
        f_hit_s    = valid_r[f_idx_s] & (tag_r[f_idx_s] == f_tag_s);
        f_taken_s  = f_hit_s & (is_jump_r[f_idx_s] | cnt_r[f_idx_s][1]);
        if (f_taken_s) f_target_s = target_r[f_idx_s];
        else           f_target_s = f_pc + XLEN'(4);
    end

    // Resolve path: real target, actual vs predicted next PC, redirect.
    always_comb begin
        r_idx_s = r_pc[IDX+1:2];
        r_tag_s = r_pc[XLEN-1:IDX+2];
        r_hit_s = valid_r[r_idx_s] & (tag_r[r_idx_s] == r_tag_s);
        r_pc4_s = r_pc + XLEN'(4);
        if (r_is_jalr) r_target = r_jalr_src;
        else           r_target = r_pc + r_sextimm;
        act_taken_s = r_is_jump | (r_is_branch & r_taken);
        if (act_taken_s) act_next_s = r_target;
        else             act_next_s = r_pc4_s;
        if (r_pred_taken) pred_next_s = r_pred_target;
        else              pred_next_s = r_pc4_s;
        train_s     = r_valid & (r_is_branch | r_is_jump);
        redirect    = train_s & (act_next_s != pred_next_s);
        redirect_pc = act_next_s;
    end

    // Registered prediction; non-valid cycles keep the previous hit/taken/target.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            p_valid  <= 1'b0;
            p_hit    <= 1'b0;
            p_taken  <= 1'b0;
            p_target <= {XLEN{1'b0}};
        end else if (f_valid) begin
            p_valid  <= 1'b1;
            p_hit    <= f_hit_s;
            p_taken  <= f_taken_s;
            p_target <= f_target_s;
        end else begin
            p_valid  <= 1'b0;
        end
    end

    // Entry valid bits: cleared by reset, set on allocation of a taken miss.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < ENTRIES; i++) valid_r[i] <= 1'b0;
        end else if (train_s && !r_hit_s && act_taken_s) begin
            valid_r[r_idx_s] <= 1'b1;
        end
    end

    // Entry payload training; contents of invalid entries are don't-care.
    always_ff @(posedge clk) begin
        if (resetn && train_s) begin
            if (r_hit_s) begin
                if (r_is_jump) begin
                    target_r[r_idx_s]  <= r_target;
                    is_jump_r[r_idx_s] <= 1'b1;
                end else begin
                    cnt_r[r_idx_s] <= cnt_next(cnt_r[r_idx_s], r_taken);
                    if (r_taken) target_r[r_idx_s] <= r_target;
                end
            end else if (act_taken_s) begin
                tag_r[r_idx_s]     <= r_tag_s;
                target_r[r_idx_s]  <= r_target;
                is_jump_r[r_idx_s] <= r_is_jump;
                cnt_r[r_idx_s]     <= 2'd2;
            end
        end
    end

endmodule
